// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: loads plaintext^key, walks the round counter through
// the external round logic, and hands the ciphertext out over valid/ready.
module aes_round_ctrl #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_text,
  input  logic [DATA_W-1:0] in_key,
  input  logic              abort,
  output logic [3:0]        round_sel,
  output logic              last_round,
  output logic [DATA_W-1:0] state_out,
  input  logic [DATA_W-1:0] round_res,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_text
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_e            st_q, st_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      rnd_q  <= 4'd0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    rnd_d  = rnd_q;
    data_d = data_q;
    unique case (st_q)
      IDLE: begin
        // abort wins over a presented block, which is then simply not taken
        if (!abort && in_valid) begin
          data_d = in_text ^ in_key;
          rnd_d  = 4'd1;
          st_d   = ROUND;
        end
      end
      ROUND: begin
        if (abort) begin
          st_d   = IDLE;
          rnd_d  = 4'd0;
          data_d = '0;
        end else begin
          data_d = round_res;
          if (rnd_q == LAST_RND) begin
            st_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          st_d   = IDLE;
          rnd_d  = 4'd0;
          data_d = '0;
        end else if (out_ready) begin
          st_d  = IDLE;
          rnd_d = 4'd0;
        end
      end
      default: begin
        st_d   = IDLE;
        rnd_d  = 4'd0;
        data_d = '0;
      end
    endcase
  end

  // rnd_q is 1..NUM_ROUNDS inside ROUND, so round_sel stays below NUM_ROUNDS
  always_comb begin
    round_sel  = 4'd0;
    last_round = 1'b0;
    if (st_q == ROUND) begin
      round_sel  = rnd_q - 4'd1;
      last_round = (rnd_q == LAST_RND);
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q == ROUND) || (st_q == DONE);
  assign out_valid = (st_q == DONE);
  assign out_text  = (st_q == DONE) ? data_q : '0;
  assign state_out = data_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption through the ten-way round-key selector and the external combinational round-function logic.
- Accepts a plaintext block and cipher key over a valid/ready handshake and performs the initial AddRoundKey.
- Steps a round counter that drives the round-key select, registers each round result, and presents the ciphertext over a valid/ready output handshake.
- Sits between the top-level I/O wrapper and the round datapath; owns the 128-bit state register.

Parameters:
- DATA_W, 128, width of state, plaintext, key and ciphertext.
- NUM_ROUNDS, 10, number of cipher rounds; must be no greater than 15 (fits round_sel).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  plaintext/key presented
- in_ready  output  1  controller can accept a block
- in_text  input  DATA_W  plaintext
- in_key  input  DATA_W  cipher key (round key 0)
- abort  input  1  synchronous cancel of the current block
- round_sel  output  4  select for round keys 1..NUM_ROUNDS (value = round-1)
- last_round  output  1  round logic must skip MixColumns
- state_out  output  DATA_W  registered state fed to the round logic
- round_res  input  DATA_W  combinational round result for state_out, round_sel, last_round
- busy  output  1  block in flight (ROUND or DONE)
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts ciphertext
- out_text  output  DATA_W  ciphertext (equals state_out in DONE)

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. While rst is high on a rising clk:
  - state = IDLE, rnd = 0, state_q = 0.
  - in_ready = 1 (follows IDLE), out_valid = 0, busy = 0, round_sel = 0, last_round = 0, out_text = 0.
- rst overrides abort and all handshakes.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid=1: state_q <= in_text XOR in_key, rnd <= 1, go to ROUND.
  - in_text and in_key are sampled only in this cycle.
- ROUND:
  - round_sel = rnd-1 (4 bits); last_round = (rnd == NUM_ROUNDS).
  - Every cycle state_q <= round_res.
  - If rnd < NUM_ROUNDS: rnd <= rnd+1.
  - If rnd == NUM_ROUNDS: go to DONE and hold rnd. The counter never exceeds NUM_ROUNDS; there is no wrap-around.
- DONE:
  - out_valid = 1, out_text = state_q, state_q held.
  - On out_ready=1: go to IDLE, rnd <= 0.
  - in_ready stays 0 in DONE; a new block cannot be accepted in the same cycle the result leaves, so the minimum issue interval is NUM_ROUNDS+2 cycles.
- Outputs when not in ROUND: round_sel = 0, last_round = 0.
- busy = 1 in ROUND and DONE.
- state_out = state_q at all times.
- Latency: handshake accepted at edge T -> out_valid high after edge T+NUM_ROUNDS (11 edges total including the load edge, NUM_ROUNDS=10).
- Backpressure: out_valid stays high and out_text stays stable until out_ready is sampled high. out_ready is ignored outside DONE.
- abort:
  - In ROUND or DONE: next state IDLE, rnd <= 0, state_q <= 0. The output is discarded with no out_valid pulse.
  - In IDLE: abort takes priority over in_valid; the block is not accepted.
- Simultaneous in_valid and out_ready in DONE: only the output completes; in_valid must be held by the source until in_ready.
- X-safety: round_sel must never take values >= NUM_ROUNDS, so the downstream selector's default branch is never reached.

Test Plan:
- FIPS-197 vector with a reference round model and key expansion in the bench:
  - Stimulus: in_text = 00112233445566778899aabbccddeeff, in_key = 000102030405060708090a0b0c0d0e0f, out_ready = 1.
  - Required: out_text = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid rises exactly 10 edges after the accept edge.
- Round sequencing: after accept, round_sel steps 0,1,...,9 on consecutive cycles; last_round = 1 only with round_sel = 9; busy = 1 throughout.
- Backpressure:
  - out_ready held 0 for 5 cycles after out_valid -> out_valid and out_text stable, in_ready = 0.
  - out_ready = 1 -> returns to IDLE next edge, in_ready = 1.
- Abort:
  - abort at round_sel = 4 -> next cycle IDLE, state_out = 0, no out_valid.
  - A following block (same FIPS vector) still yields 69c4e0d8...c55a.
- Reset mid-operation:
  - rst pulsed during round_sel = 6 -> all outputs at reset values on the next edge, in_ready = 1.
  - in_valid held during rst is not accepted.
- Back-to-back: two blocks with in_valid held continuously -> the second is accepted on the edge after the first output handshake; both ciphertexts are correct.
